// File: rtl/rt_irq_pkg.sv
// Shared definitions for the rt_irq_ctrl interrupt controller.
package rt_irq_pkg;

  localparam int unsigned IRQ_ID_W = 3;

  localparam logic [3:0] IRQ_ENABLE     = 4'h0;
  localparam logic [3:0] IRQ_PENDING    = 4'h1;
  localparam logic [3:0] IRQ_EDGE_SEL   = 4'h2;
  localparam logic [3:0] IRQ_IN_SERVICE = 4'h3;
  localparam logic [3:0] IRQ_CURRENT    = 4'h4;
  localparam logic [3:0] IRQ_SWTRIG     = 4'h5;

  typedef enum logic [0:0] {
    IRQ_IDLE,
    IRQ_REQ
  } irq_state_t;

endpackage

// File: rtl/rt_irq_prio_enc.sv
// Find-first-set over N bits; index 0 has the highest priority.
module rt_irq_prio_enc
  import rt_irq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]        bits,
  output logic [IRQ_ID_W-1:0] id,
  output logic                valid
);

  // Scan from the top so the lowest set index is the last assignment to land.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (bits[i]) begin
        id    = IRQ_ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rt_irq_ctrl.sv
// Fixed-priority interrupt controller with req/ack/eoi handshake to the core.
// Define RT_IRQ_NESTING_EN to let higher-priority sources preempt an in-service handler.
module rt_irq_ctrl
  import rt_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reg_en,
  input  logic                reg_we,
  input  logic [3:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  input  logic [NUM_SRC-1:0]  irq_src,
  output logic                cpu_irq_req,
  output logic [IRQ_ID_W-1:0] cpu_irq_id,
  input  logic                cpu_irq_ack,
  input  logic                cpu_irq_eoi
);

  logic [NUM_SRC-1:0]  enable_q, edge_sel_q, src_q;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  in_service_q, in_service_d;
  logic [IRQ_ID_W-1:0] id_q;
  logic [31:0]         rdata_q, rdata_d;
  irq_state_t          state_q, state_d;

  logic                reg_wr, reg_rd;
  logic [NUM_SRC-1:0]  wdata_src, w1c, swtrig, rise;
  logic [NUM_SRC-1:0]  cand_bits, cur_mask, ins_mask, take_mask;
  logic [IRQ_ID_W-1:0] cand_id, ins_id;
  logic                cand_valid, ins_valid, eligible, cur_live, take;
  logic                unused_wdata;

  assign reg_wr       = reg_en & reg_we;
  assign reg_rd       = reg_en & ~reg_we;
  assign wdata_src    = reg_wdata[NUM_SRC-1:0];
  assign unused_wdata = ^reg_wdata[31:NUM_SRC];
  assign w1c          = (reg_wr && reg_addr == IRQ_PENDING) ? wdata_src : '0;
  assign swtrig       = (reg_wr && reg_addr == IRQ_SWTRIG) ? wdata_src : '0;
  assign rise         = irq_src & ~src_q;
  assign cand_bits    = pending_q & enable_q & ~in_service_q;

  rt_irq_prio_enc #(
    .N (NUM_SRC)
  ) u_cand_enc (
    .bits  (cand_bits),
    .id    (cand_id),
    .valid (cand_valid)
  );

  rt_irq_prio_enc #(
    .N (NUM_SRC)
  ) u_ins_enc (
    .bits  (in_service_q),
    .id    (ins_id),
    .valid (ins_valid)
  );

`ifdef RT_IRQ_NESTING_EN
  assign eligible = cand_valid && (!ins_valid || (cand_id < ins_id));
`else
  assign eligible = cand_valid && !ins_valid;
`endif

  always_comb begin
    cur_mask = '0;
    ins_mask = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      cur_mask[i] = (id_q == IRQ_ID_W'(i));
      ins_mask[i] = ins_valid && (ins_id == IRQ_ID_W'(i));
    end
  end

  // The request stays meaningful only while its source is still pending and enabled.
  assign cur_live = |(cur_mask & pending_q & enable_q);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IRQ_IDLE: if (eligible) state_d = IRQ_REQ;
      IRQ_REQ:  if (cpu_irq_ack || !cur_live) state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cpu_irq_req = (state_q == IRQ_REQ);
    cpu_irq_id  = id_q;
    take        = (state_q == IRQ_REQ) && cpu_irq_ack;
    take_mask   = take ? cur_mask : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
    end else if (state_q == IRQ_IDLE && eligible) begin
      id_q <= cand_id;
    end
  end

  // New edges and software triggers win over same-cycle clears.
  always_comb begin
    pending_d    = (edge_sel_q & ((pending_q & ~w1c & ~take_mask) | rise | swtrig)) |
                   (~edge_sel_q & irq_src);
    in_service_d = (in_service_q & ~(cpu_irq_eoi ? ins_mask : '0)) | take_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      src_q        <= irq_src;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q   <= '0;
      edge_sel_q <= '0;
    end else if (reg_wr) begin
      if (reg_addr == IRQ_ENABLE)   enable_q   <= wdata_src;
      if (reg_addr == IRQ_EDGE_SEL) edge_sel_q <= wdata_src;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (reg_rd) begin
      case (reg_addr)
        IRQ_ENABLE:     rdata_d = 32'(enable_q);
        IRQ_PENDING:    rdata_d = 32'(pending_q);
        IRQ_EDGE_SEL:   rdata_d = 32'(edge_sel_q);
        IRQ_IN_SERVICE: rdata_d = 32'(in_service_q);
        IRQ_CURRENT:    rdata_d = {cpu_irq_req, 28'd0, id_q};
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_rt_irq_ctrl.sv
// Directed plus randomized bench for rt_irq_ctrl against a rule-level reference model.
module tb_rt_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_en = 1'b0;
  logic        reg_we = 1'b0;
  logic [3:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic [7:0]  irq_src = '0;
  logic        cpu_irq_req;
  logic [2:0]  cpu_irq_id;
  logic        cpu_irq_ack = 1'b0;
  logic        cpu_irq_eoi = 1'b0;

  int total = 0;
  int bad = 0;

  // reference model state
  bit [7:0]  m_en, m_pend, m_es, m_ins, m_srcq;
  bit        m_req;
  bit [2:0]  m_id;
  bit [31:0] m_rdata;

  rt_irq_ctrl #(
    .NUM_SRC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_en      (reg_en),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .irq_src     (irq_src),
    .cpu_irq_req (cpu_irq_req),
    .cpu_irq_id  (cpu_irq_id),
    .cpu_irq_ack (cpu_irq_ack),
    .cpu_irq_eoi (cpu_irq_eoi)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic model_reset();
    m_en = '0; m_pend = '0; m_es = '0; m_ins = '0; m_srcq = '0;
    m_req = 1'b0; m_id = '0; m_rdata = '0;
  endtask

  // One clock of the controller's rules, using the pre-edge state throughout.
  task automatic model_step();
    bit [7:0] src, p_n, i_n;
    bit       elig, take, wr, p;
    int       c, h;
    src  = irq_src;
    wr   = reg_en && reg_we;
    c    = lowest(m_pend & m_en & ~m_ins);
    h    = lowest(m_ins);
`ifdef RT_IRQ_NESTING_EN
    elig = (c < 8) && (c < h);
`else
    elig = (c < 8) && (h == 8);
`endif
    take = m_req && cpu_irq_ack;
    if (reg_en && !reg_we) begin
      case (reg_addr)
        4'd0:    m_rdata = {24'd0, m_en};
        4'd1:    m_rdata = {24'd0, m_pend};
        4'd2:    m_rdata = {24'd0, m_es};
        4'd3:    m_rdata = {24'd0, m_ins};
        4'd4:    m_rdata = {m_req, 28'd0, m_id};
        default: m_rdata = 32'd0;
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      if (m_es[i]) begin
        p = m_pend[i];
        if (wr && reg_addr == 4'd1 && reg_wdata[i]) p = 1'b0;
        if (take && int'(m_id) == i) p = 1'b0;
        if ((src[i] && !m_srcq[i]) || (wr && reg_addr == 4'd5 && reg_wdata[i])) p = 1'b1;
        p_n[i] = p;
      end else begin
        p_n[i] = src[i];
      end
    end
    i_n = m_ins;
    if (cpu_irq_eoi && h < 8) i_n[h] = 1'b0;
    if (take) i_n[m_id] = 1'b1;
    if (!m_req) begin
      if (elig) begin
        m_req = 1'b1;
        m_id  = c[2:0];
      end
    end else if (take || !(m_pend[m_id] && m_en[m_id])) begin
      m_req = 1'b0;
    end
    if (wr && reg_addr == 4'd0) m_en = reg_wdata[7:0];
    if (wr && reg_addr == 4'd2) m_es = reg_wdata[7:0];
    m_pend = p_n;
    m_ins  = i_n;
    m_srcq = src;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("req", 32'(cpu_irq_req), 32'(m_req));
    if (m_req) check("id", 32'(cpu_irq_id), 32'(m_id));
    check("rdata", reg_rdata, m_rdata);
    reg_en = 1'b0; reg_we = 1'b0; cpu_irq_ack = 1'b0; cpu_irq_eoi = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
  endtask

  task automatic rd_exp(input string tag, input logic [3:0] a, input logic [31:0] exp);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = a;
    tick();
    check(tag, reg_rdata, exp);
  endtask

  task automatic do_ack();
    cpu_irq_ack = 1'b1;
    tick();
  endtask

  task automatic do_eoi();
    cpu_irq_eoi = 1'b1;
    tick();
  endtask

  initial begin
    bit [7:0] t;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(cpu_irq_req), 32'd0);
    check("rst_id", 32'(cpu_irq_id), 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    rst_n = 1'b1;
    rd_exp("rst_en", 4'd0, 32'd0);
    rd_exp("rst_ins", 4'd3, 32'd0);

    // edge detect and latency
    wr(4'd2, 32'h0F);
    wr(4'd0, 32'h01);
    idle(3);
    irq_src[0] = 1'b1;
    tick();
    check("edge_n1_req", 32'(cpu_irq_req), 32'd0);
    tick();
    check("edge_n2_req", 32'(cpu_irq_req), 32'd1);
    check("edge_n2_id", 32'(cpu_irq_id), 32'd0);
    do_ack();
    check("ack_drop", 32'(cpu_irq_req), 32'd0);
    rd_exp("edge_pend", 4'd1, 32'h00);
    rd_exp("edge_ins", 4'd3, 32'h01);
    do_eoi();
    rd_exp("edge_ins_eoi", 4'd3, 32'h00);
    irq_src[0] = 1'b0;
    tick();

    // priority between simultaneous sources 2 and 5
    wr(4'd2, 32'h3F);
    wr(4'd0, 32'h24);
    irq_src = irq_src | 8'h24;
    idle(2);
    check("prio_id", 32'(cpu_irq_id), 32'd2);
    do_ack();
    idle(2);
    check("prio_blocked", 32'(cpu_irq_req), 32'd0);
    do_eoi();
    check("prio_k1", 32'(cpu_irq_req), 32'd0);
    tick();
    check("prio_k2_req", 32'(cpu_irq_req), 32'd1);
    check("prio_k2_id", 32'(cpu_irq_id), 32'd5);
    do_ack();
    do_eoi();
    irq_src = irq_src & ~8'h24;
    tick();

    // masking and write-1-clear
    wr(4'd0, 32'h00);
    irq_src[3] = 1'b1;
    idle(3);
    check("mask_noreq", 32'(cpu_irq_req), 32'd0);
    rd_exp("mask_pend", 4'd1, 32'h08);
    wr(4'd1, 32'h08);
    rd_exp("w1c_pend", 4'd1, 32'h00);
    irq_src[3] = 1'b0;
    tick();
    irq_src[3] = 1'b1;
    wr(4'd1, 32'h08);
    rd_exp("w1c_race", 4'd1, 32'h08);
    irq_src[3] = 1'b0;
    wr(4'd1, 32'h08);
    rd_exp("w1c_final", 4'd1, 32'h00);

    // nesting behaviour
    wr(4'd0, 32'h12);
    irq_src[4] = 1'b1;
    idle(2);
    check("nest_id4", 32'(cpu_irq_id), 32'd4);
    do_ack();
    irq_src[1] = 1'b1;
    idle(2);
`ifdef RT_IRQ_NESTING_EN
    check("nest_req", 32'(cpu_irq_req), 32'd1);
    check("nest_id1", 32'(cpu_irq_id), 32'd1);
    do_ack();
    rd_exp("nest_ins", 4'd3, 32'h12);
    do_eoi();
    rd_exp("nest_ins_eoi1", 4'd3, 32'h10);
    do_eoi();
`else
    check("nonest_req", 32'(cpu_irq_req), 32'd0);
    rd_exp("nonest_ins", 4'd3, 32'h10);
    do_eoi();
    tick();
    check("nonest_req_k2", 32'(cpu_irq_req), 32'd1);
    check("nonest_id1", 32'(cpu_irq_id), 32'd1);
    do_ack();
    do_eoi();
`endif
    rd_exp("nest_ins_done", 4'd3, 32'h00);
    irq_src = '0;
    tick();

    // level source re-requests while held
    wr(4'd0, 32'h40);
    irq_src[6] = 1'b1;
    idle(2);
    check("lvl_id", 32'(cpu_irq_id), 32'd6);
    do_ack();
    check("lvl_ack_drop", 32'(cpu_irq_req), 32'd0);
    do_eoi();
    tick();
    check("lvl_rereq", 32'(cpu_irq_req), 32'd1);
    wr(4'd1, 32'h40);
    rd_exp("lvl_w1c", 4'd1, 32'h40);
    do_ack();
    irq_src[6] = 1'b0;
    do_eoi();
    idle(4);
    check("lvl_gone", 32'(cpu_irq_req), 32'd0);

    // reset while a request is outstanding
    wr(4'd0, 32'h01);
    irq_src[0] = 1'b1;
    idle(2);
    check("prerst_req", 32'(cpu_irq_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(cpu_irq_req), 32'd0);
    check("midrst_id", 32'(cpu_irq_id), 32'd0);
    check("midrst_rdata", reg_rdata, 32'd0);
    model_reset();
    irq_src = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_exp("postrst_en", 4'd0, 32'd0);
    rd_exp("postrst_pend", 4'd1, 32'd0);
    rd_exp("postrst_es", 4'd2, 32'd0);
    idle(4);
    check("postrst_noreq", 32'(cpu_irq_req), 32'd0);

    // randomized traffic against the model
    wr(4'd0, 32'hFF);
    wr(4'd2, 32'($urandom_range(255)));
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(5) == 0) begin
        t = 8'h01 << $urandom_range(7);
        irq_src = irq_src ^ t;
      end
      cpu_irq_ack = 1'($urandom_range(2) == 0);
      cpu_irq_eoi = 1'($urandom_range(6) == 0);
      if ($urandom_range(3) == 0) begin
        reg_en    = 1'b1;
        reg_we    = 1'($urandom_range(1));
        reg_addr  = ($urandom_range(9) == 0) ? 4'hF : 4'($urandom_range(7));
        reg_wdata = $urandom;
        if (reg_we && reg_addr == 4'd0 && $urandom_range(1) == 0) reg_wdata = 32'hFF;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
